// File: rtl/aes_dec_pkg.sv
// Shared constants and helpers for the iterative AES-128 inverse cipher:
// FSM state type, forward/inverse S-boxes, round constants, GF(2^8)
// arithmetic and the forward/backward key-schedule steps.
package aes_dec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_ARK,
        ST_ROUND,
        ST_DONE
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    // K(i-1) -> K(i), using the round constant of step i.
    function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h000000};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // K(i) -> K(i-1), using the round constant of step i.
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the last round.
// Byte i of the 128-bit word is bits [127-8i -: 8]; state[r][c] = byte r+4c.
module aes_inv_round
    import aes_dec_pkg::*;
(
    input  logic [127:0] st_in,
    input  logic [127:0] rk_in,
    input  logic         last,
    output logic [127:0] st_out
);

    logic [7:0] b_in  [16];
    logic [7:0] b_ark [16];
    logic [7:0] b_out [16];

    // Byte-level inverse round datapath.
    always_comb begin
        st_out = '0;
        for (int i = 0; i < 16; i++) begin
            b_in[i] = st_in[127-8*i -: 8];
        end
        // Row r is rotated right by r columns, then inverse-substituted and keyed.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b_ark[r+4*c] = INV_SBOX[b_in[r + 4*((c - r + 4) % 4)]] ^ rk_in[127-8*(r+4*c) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) b_out[r+4*c] = b_ark[r+4*c];
            end else begin
                b_out[4*c+0] = gmul(b_ark[4*c], 8'h0e) ^ gmul(b_ark[4*c+1], 8'h0b)
                             ^ gmul(b_ark[4*c+2], 8'h0d) ^ gmul(b_ark[4*c+3], 8'h09);
                b_out[4*c+1] = gmul(b_ark[4*c], 8'h09) ^ gmul(b_ark[4*c+1], 8'h0e)
                             ^ gmul(b_ark[4*c+2], 8'h0b) ^ gmul(b_ark[4*c+3], 8'h0d);
                b_out[4*c+2] = gmul(b_ark[4*c], 8'h0d) ^ gmul(b_ark[4*c+1], 8'h09)
                             ^ gmul(b_ark[4*c+2], 8'h0e) ^ gmul(b_ark[4*c+3], 8'h0b);
                b_out[4*c+3] = gmul(b_ark[4*c], 8'h0b) ^ gmul(b_ark[4*c+1], 8'h0d)
                             ^ gmul(b_ark[4*c+2], 8'h09) ^ gmul(b_ark[4*c+3], 8'h0e);
            end
        end
        for (int i = 0; i < 16; i++) begin
            st_out[127-8*i -: 8] = b_out[i];
        end
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption, one round per clock.
// Optional macro AES_INV_KEY_CACHE_EN: remembers the last expanded key so a
// repeated key skips the 10-cycle forward expansion to K10.
//
// state  | meaning
// IDLE   | waiting for AES_en; captures ciphertext and key
// KEYEXP | forward key schedule K0 -> K10, one step per cycle
// ARK    | initial AddRoundKey with K10
// ROUND  | inverse rounds 9..0, key stepped backward alongside
// DONE   | AES_data_out_valid high for this one cycle
module aes_inv_cipher_iter
    import aes_dec_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid,
    output logic         AES_busy
);

    localparam logic [3:0] NR_CNT = 4'(NR);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] data_out_q, data_out_d;

    logic [3:0]   rcon_idx;
    logic [7:0]   rcon_sel;
    logic [127:0] rk_fwd;
    logic [127:0] rk_bwd;
    logic [127:0] round_out;

`ifdef AES_INV_KEY_CACHE_EN
    logic [127:0] key_cache_tag_q, key_cache_tag_d;
    logic [127:0] key_cache_k10_q, key_cache_k10_d;
    logic         cache_vld_q, cache_vld_d;
    logic         cache_hit;
`endif

    // Round-constant select and the two key-schedule directions.
    always_comb begin
        rcon_idx = (cnt_q >= 4'd1 && cnt_q <= 4'd10) ? cnt_q : 4'd1;
        rcon_sel = RCON[rcon_idx];
        rk_fwd   = fwd_key_step(rk_q, rcon_sel);
        rk_bwd   = inv_key_step(rk_q, rcon_sel);
    end

    aes_inv_round u_round (
        .st_in  (st_q),
        .rk_in  (rk_bwd),
        .last   (cnt_q == 4'd1),
        .st_out (round_out)
    );

`ifdef AES_INV_KEY_CACHE_EN
    assign cache_hit = cache_vld_q && (AES_key_in == key_cache_tag_q);
`endif

    // Next-state, counter and datapath register updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        st_d       = st_q;
        rk_d       = rk_q;
        data_out_d = data_out_q;
`ifdef AES_INV_KEY_CACHE_EN
        key_cache_tag_d = key_cache_tag_q;
        key_cache_k10_d = key_cache_k10_q;
        cache_vld_d     = cache_vld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (AES_en) begin
                    st_d    = AES_data_in;
                    rk_d    = AES_key_in;
                    cnt_d   = 4'd1;
                    state_d = ST_KEYEXP;
`ifdef AES_INV_KEY_CACHE_EN
                    if (cache_hit) begin
                        rk_d    = key_cache_k10_q;
                        state_d = ST_ARK;
                    end else begin
                        // Tag is invalid until the matching K10 is written.
                        key_cache_tag_d = AES_key_in;
                        cache_vld_d     = 1'b0;
                    end
`endif
                end
            end
            ST_KEYEXP: begin
                rk_d  = rk_fwd;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == NR_CNT) begin
                    state_d = ST_ARK;
`ifdef AES_INV_KEY_CACHE_EN
                    key_cache_k10_d = rk_fwd;
                    cache_vld_d     = 1'b1;
`endif
                end
            end
            ST_ARK: begin
                st_d    = st_q ^ rk_q;
                cnt_d   = NR_CNT;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                st_d  = round_out;
                rk_d  = rk_bwd;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    data_out_d = round_out;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            st_q       <= '0;
            rk_q       <= '0;
            data_out_q <= '0;
`ifdef AES_INV_KEY_CACHE_EN
            key_cache_tag_q <= '0;
            key_cache_k10_q <= '0;
            cache_vld_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            st_q       <= st_d;
            rk_q       <= rk_d;
            data_out_q <= data_out_d;
`ifdef AES_INV_KEY_CACHE_EN
            key_cache_tag_q <= key_cache_tag_d;
            key_cache_k10_q <= key_cache_k10_d;
            cache_vld_q     <= cache_vld_d;
`endif
        end
    end

    assign AES_data_out       = data_out_q;
    assign AES_data_out_valid = (state_q == ST_DONE);
    assign AES_busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: known-answer vectors, continuous
// enable streaming, mid-operation reset and (with AES_INV_KEY_CACHE_EN)
// key-cache latency.
module tb_aes_inv_cipher_iter;

    logic         clk;
    logic         rst;
    logic         en;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic [127:0] data_out;
    logic         valid;
    logic         busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs [3];

    aes_inv_cipher_iter #(.NR(10)) dut (
        .AES_clk            (clk),
        .AES_rst            (rst),
        .AES_en             (en),
        .AES_data_in        (data_in),
        .AES_key_in         (key_in),
        .AES_data_out       (data_out),
        .AES_data_out_valid (valid),
        .AES_busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] garbage();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Start one block at the next IDLE edge and follow it to completion.
    task automatic run_block(input int vi, input int exp_lat, input string tag);
        int lat;
        bit busy_ok;
        @(negedge clk);
        en      = 1'b1;
        data_in = vecs[vi].ct;
        key_in  = vecs[vi].key;
        @(posedge clk);
        @(negedge clk);
        en      = 1'b0;
        data_in = garbage();
        key_in  = garbage();
        busy_ok = busy;
        lat     = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (!busy) busy_ok = 1'b0;
            if (valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "_pt"}, data_out, vecs[vi].pt);
        check({tag, "_busy"}, 128'(busy_ok), 128'd1);
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 128'({valid, busy}), 128'd0);
        check({tag, "_hold"}, data_out, vecs[vi].pt);
    endtask

    initial begin
        int pulses;
        int valid_errs;
        int stable_errs;
        int late_pulses;
        logic [127:0] exp_out;

        vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    pt:  128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32,
                    pt:  128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{key: 128'h0,
                    ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    pt:  128'h0};

        rst     = 1'b1;
        en      = 1'b0;
        data_in = '0;
        key_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", data_out, 128'h0);
        check("rst_valid", 128'(valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 3; v++) begin
            run_block(v, 21, $sformatf("kat%0d", v));
        end

        // Continuous enable: captures only at edges 0, 23, 46.
        exp_out     = vecs[2].pt;
        pulses      = 0;
        valid_errs  = 0;
        stable_errs = 0;
        for (int n = 0; n < 75; n++) begin
            @(negedge clk);
            en = (n < 60);
            if (n % 23 == 0) begin
                data_in = vecs[(n / 23) % 3].ct;
                key_in  = vecs[(n / 23) % 3].key;
            end else begin
                data_in = garbage();
                key_in  = garbage();
            end
            @(posedge clk);
            #1;
            if (valid !== ((n == 21) || (n == 44) || (n == 67))) valid_errs++;
            if (valid) begin
                exp_out = vecs[pulses % 3].pt;
                check($sformatf("stream_pt%0d", pulses), data_out, exp_out);
                pulses++;
            end else if (data_out !== exp_out) begin
                stable_errs++;
            end
        end
        en = 1'b0;
        check("stream_pulses", 128'(pulses), 128'd3);
        check("stream_valid_timing", 128'(valid_errs), 128'd0);
        check("stream_out_stable", 128'(stable_errs), 128'd0);

        // Reset sampled at edge E8 of an operation.
        run_block(0, 21, "pre_rst");
        @(negedge clk);
        en      = 1'b1;
        data_in = vecs[1].ct;
        key_in  = vecs[1].key;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_data_out", data_out, 128'h0);
        check("midrst_valid", 128'(valid), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        late_pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (valid || busy) late_pulses++;
        end
        check("midrst_no_pulse", 128'(late_pulses), 128'd0);
        run_block(1, 21, "post_rst");

`ifdef AES_INV_KEY_CACHE_EN
        run_block(0, 21, "cache_miss");
        run_block(0, 11, "cache_hit");
        run_block(1, 21, "cache_newkey");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
